// File: rtl/reg_file_write_arbiter.sv
// reg_file_write_arbiter
// Shares the register file's single write port among NUM_REQ writeback
// sources. Each source owns a one-entry holding buffer with a valid/ready
// handshake. A round-robin arbiter moves one buffered write per cycle into a
// registered output stage. Query ports report pending writes for RAW stalls.
//
// Optional feature macro: REG_FILE_WRITE_ARB_R0_DISCARD_EN
//   When defined, writes to register 0 are accepted but dropped, and r0 is
//   never reported as pending. When undefined, r0 behaves like any register.
module reg_file_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int SEL_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_QUERY  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              in_valid,
    output logic [NUM_REQ-1:0]              in_ready,
    input  logic [NUM_REQ*SEL_WIDTH-1:0]    in_sel,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   in_data,
    output logic                            out_write_en,
    output logic [SEL_WIDTH-1:0]            out_write_sel,
    output logic [DATA_WIDTH-1:0]           out_write_data,
    input  logic [NUM_QUERY*SEL_WIDTH-1:0]  query_sel,
    output logic [NUM_QUERY-1:0]            query_pending,
    output logic                            idle
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Per-requester views of the flattened input buses
    logic [NUM_REQ-1:0][SEL_WIDTH-1:0]    in_sel_arr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   in_data_arr;
    logic [NUM_QUERY-1:0][SEL_WIDTH-1:0]  query_arr;

    assign in_sel_arr  = in_sel;
    assign in_data_arr = in_data;
    assign query_arr   = query_sel;

    // Holding buffers
    logic [NUM_REQ-1:0]                   buf_valid_q, buf_valid_d;
    logic [NUM_REQ-1:0][SEL_WIDTH-1:0]    buf_sel_q,   buf_sel_d;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   buf_data_q,  buf_data_d;

    // Round-robin pointer: index where the next scan starts
    logic [PTR_W-1:0]                     rr_ptr_q, rr_ptr_d;

    // Registered output stage feeding the register file write port
    logic                                 out_write_en_q,   out_write_en_d;
    logic [SEL_WIDTH-1:0]                 out_write_sel_q,  out_write_sel_d;
    logic [DATA_WIDTH-1:0]                out_write_data_q, out_write_data_d;

    // Arbitration result
    logic                                 grant_valid;
    logic [PTR_W-1:0]                     grant_idx;
    logic [PTR_W:0]                       scan_idx;

    // Ready depends only on buffer state, never on in_valid
    assign in_ready = ~buf_valid_q;

    // Round-robin scan: first valid buffer at or after rr_ptr_q, with wrap
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_valid && buf_valid_q[scan_idx[PTR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    // Buffer next state: grant empties a buffer, handshake fills an empty one
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_sel_d   = buf_sel_q;
        buf_data_d  = buf_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && (grant_idx == PTR_W'(i))) begin
                buf_valid_d[i] = 1'b0;
            end else if (in_valid[i] && !buf_valid_q[i]) begin
`ifdef REG_FILE_WRITE_ARB_R0_DISCARD_EN
                // Handshake still completes; an r0 write is simply dropped
                buf_valid_d[i] = (in_sel_arr[i] != '0);
`else
                buf_valid_d[i] = 1'b1;
`endif
                buf_sel_d[i]   = in_sel_arr[i];
                buf_data_d[i]  = in_data_arr[i];
            end
        end
    end

    // Output stage and pointer next state; sel/data hold when nothing wins
    always_comb begin
        out_write_en_d   = 1'b0;
        out_write_sel_d  = out_write_sel_q;
        out_write_data_d = out_write_data_q;
        rr_ptr_d         = rr_ptr_q;
        if (grant_valid) begin
            out_write_en_d   = 1'b1;
            out_write_sel_d  = buf_sel_q[grant_idx];
            out_write_data_d = buf_data_q[grant_idx];
            rr_ptr_d         = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                  : grant_idx + PTR_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid_q      <= '0;
            buf_sel_q        <= '0;
            buf_data_q       <= '0;
            rr_ptr_q         <= '0;
            out_write_en_q   <= 1'b0;
            out_write_sel_q  <= '0;
            out_write_data_q <= '0;
        end else begin
            buf_valid_q      <= buf_valid_d;
            buf_sel_q        <= buf_sel_d;
            buf_data_q       <= buf_data_d;
            rr_ptr_q         <= rr_ptr_d;
            out_write_en_q   <= out_write_en_d;
            out_write_sel_q  <= out_write_sel_d;
            out_write_data_q <= out_write_data_d;
        end
    end

    assign out_write_en   = out_write_en_q;
    assign out_write_sel  = out_write_sel_q;
    assign out_write_data = out_write_data_q;
    assign idle           = !(|buf_valid_q) && !out_write_en_q;

    // Hazard lookup per query port: any valid buffer or the output stage
    genvar gi;
    generate
        for (gi = 0; gi < NUM_QUERY; gi++) begin : g_query
            logic [NUM_REQ-1:0] buf_hit;
            logic               out_hit;

            // Compare the queried register against every holding buffer
            always_comb begin
                buf_hit = '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    buf_hit[i] = buf_valid_q[i] && (buf_sel_q[i] == query_arr[gi]);
                end
            end

            assign out_hit = out_write_en_q && (out_write_sel_q == query_arr[gi]);

`ifdef REG_FILE_WRITE_ARB_R0_DISCARD_EN
            assign query_pending[gi] = (query_arr[gi] != '0) && ((|buf_hit) || out_hit);
`else
            assign query_pending[gi] = (|buf_hit) || out_hit;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Directed testbench for reg_file_write_arbiter with hand-computed expectations.
module tb_reg_file_write_arbiter;

    localparam int NUM_REQ    = 3;
    localparam int SEL_WIDTH  = 4;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_QUERY  = 2;

    logic                            clk;
    logic                            rst_n;
    logic [NUM_REQ-1:0]              in_valid;
    logic [NUM_REQ-1:0]              in_ready;
    logic [NUM_REQ*SEL_WIDTH-1:0]    in_sel;
    logic [NUM_REQ*DATA_WIDTH-1:0]   in_data;
    logic                            out_write_en;
    logic [SEL_WIDTH-1:0]            out_write_sel;
    logic [DATA_WIDTH-1:0]           out_write_data;
    logic [NUM_QUERY*SEL_WIDTH-1:0]  query_sel;
    logic [NUM_QUERY-1:0]            query_pending;
    logic                            idle;

    int check_cnt;
    int err_cnt;

    reg_file_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .SEL_WIDTH  (SEL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_QUERY  (NUM_QUERY)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sel         (in_sel),
        .in_data        (in_data),
        .out_write_en   (out_write_en),
        .out_write_sel  (out_write_sel),
        .out_write_data (out_write_data),
        .query_sel      (query_sel),
        .query_pending  (query_pending),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [SEL_WIDTH-1:0] sel,
                           input logic [DATA_WIDTH-1:0] data);
        in_sel[idx*SEL_WIDTH +: SEL_WIDTH]    = sel;
        in_data[idx*DATA_WIDTH +: DATA_WIDTH] = data;
    endtask

    task automatic set_query(input logic [SEL_WIDTH-1:0] q0, input logic [SEL_WIDTH-1:0] q1);
        query_sel = {q1, q0};
    endtask

    initial begin
        check_cnt = 0;
        err_cnt   = 0;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_sel    = '0;
        in_data   = '0;
        query_sel = '0;

        // 1. Reset then idle
        tick();
        tick();
        check_eq("rst_in_ready", 64'(in_ready), 64'h7);
        check_eq("rst_idle", 64'(idle), 64'h1);
        check_eq("rst_out_en", 64'(out_write_en), 64'h0);
        check_eq("rst_out_sel", 64'(out_write_sel), 64'h0);
        check_eq("rst_out_data", 64'(out_write_data), 64'h0);
        check_eq("rst_qp", 64'(query_pending), 64'h0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_idle", 64'(idle), 64'h1);
        check_eq("post_rst_out_en", 64'(out_write_en), 64'h0);

        // 2. Single write through requester 0
        set_req(0, 4'd5, 32'hDEADBEEF);
        set_query(4'd5, 4'd7);
        in_valid = 3'b001;
        #1;
        check_eq("t2_qp_before", 64'(query_pending), 64'h0);
        tick();                                  // edge 1: captured
        in_valid = 3'b000;
        check_eq("t2_e1_in_ready", 64'(in_ready), 64'h6);
        check_eq("t2_e1_out_en", 64'(out_write_en), 64'h0);
        check_eq("t2_e1_qp", 64'(query_pending), 64'h1);
        check_eq("t2_e1_idle", 64'(idle), 64'h0);
        tick();                                  // edge 2: committed
        check_eq("t2_e2_out_en", 64'(out_write_en), 64'h1);
        check_eq("t2_e2_out_sel", 64'(out_write_sel), 64'h5);
        check_eq("t2_e2_out_data", 64'(out_write_data), 64'hDEADBEEF);
        check_eq("t2_e2_qp", 64'(query_pending), 64'h1);
        check_eq("t2_e2_in_ready", 64'(in_ready), 64'h7);
        tick();                                  // edge 3: drained
        check_eq("t2_e3_out_en", 64'(out_write_en), 64'h0);
        check_eq("t2_e3_qp", 64'(query_pending), 64'h0);
        check_eq("t2_e3_sel_hold", 64'(out_write_sel), 64'h5);
        check_eq("t2_e3_data_hold", 64'(out_write_data), 64'hDEADBEEF);
        check_eq("t2_e3_idle", 64'(idle), 64'h1);

        // Reset pulse so the round-robin pointer starts at 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // 3. All requesters hold valid: commit order 1,2,3,1,2,3
        set_req(0, 4'd1, 32'h0000_0101);
        set_req(1, 4'd2, 32'h0000_0102);
        set_req(2, 4'd3, 32'h0000_0103);
        in_valid = 3'b111;
        tick();                                  // all three captured
        check_eq("t3_cap_in_ready", 64'(in_ready), 64'h0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check_eq($sformatf("t3_c%0d_en", c), 64'(out_write_en), 64'h1);
            check_eq($sformatf("t3_c%0d_sel", c), 64'(out_write_sel), 64'((c % 3) + 1));
            check_eq($sformatf("t3_c%0d_data", c), 64'(out_write_data),
                     64'(32'h100 + (c % 3) + 1));
            check_eq($sformatf("t3_c%0d_ready", c), 64'(in_ready), 64'(1 << (c % 3)));
        end
        // Buffers 0 and 1 were refilled; pointer is at 0
        in_valid = 3'b000;
        tick();
        check_eq("t3_drain0_sel", 64'(out_write_sel), 64'h1);
        check_eq("t3_drain0_en", 64'(out_write_en), 64'h1);
        tick();
        check_eq("t3_drain1_sel", 64'(out_write_sel), 64'h2);
        check_eq("t3_drain1_en", 64'(out_write_en), 64'h1);
        tick();
        check_eq("t3_drain_done_en", 64'(out_write_en), 64'h0);
        check_eq("t3_drain_idle", 64'(idle), 64'h1);

        // 4. Reset mid-operation discards buffers 0 and 2
        set_req(0, 4'd9, 32'h9999_9999);
        set_req(2, 4'd10, 32'hAAAA_AAAA);
        set_query(4'd9, 4'd10);
        in_valid = 3'b101;
        tick();
        in_valid = 3'b000;
        check_eq("t4_full_ready", 64'(in_ready), 64'h2);
        check_eq("t4_full_qp", 64'(query_pending), 64'h3);
        rst_n = 1'b0;
        tick();
        check_eq("t4_rst_en", 64'(out_write_en), 64'h0);
        check_eq("t4_rst_idle", 64'(idle), 64'h1);
        check_eq("t4_rst_ready", 64'(in_ready), 64'h7);
        check_eq("t4_rst_qp", 64'(query_pending), 64'h0);
        rst_n = 1'b1;
        tick();
        check_eq("t4_after1_en", 64'(out_write_en), 64'h0);
        tick();
        check_eq("t4_after2_en", 64'(out_write_en), 64'h0);
        check_eq("t4_after2_idle", 64'(idle), 64'h1);

        // 5. Back-pressure on requester 1 (pointer 0, so req0 wins first)
        set_req(0, 4'd4, 32'hAAAA_0000);
        set_req(1, 4'd6, 32'h0BAD_F00D);
        set_query(4'd7, 4'd0);
        in_valid = 3'b011;
        tick();                                  // edge a: both captured
        in_valid = 3'b010;
        set_req(1, 4'd7, 32'h1234_5678);
        check_eq("t5_a_ready1", 64'(in_ready[1]), 64'h0);
        tick();                                  // edge b: req0 committed
        check_eq("t5_b_ready1", 64'(in_ready[1]), 64'h0);
        check_eq("t5_b_sel", 64'(out_write_sel), 64'h4);
        check_eq("t5_b_data", 64'(out_write_data), 64'hAAAA_0000);
        tick();                                  // edge c: old req1 committed
        check_eq("t5_c_data", 64'(out_write_data), 64'h0BAD_F00D);
        check_eq("t5_c_ready1", 64'(in_ready[1]), 64'h1);
        check_eq("t5_c_qp7", 64'(query_pending[0]), 64'h0);
        tick();                                  // edge d: 0x12345678 captured
        in_valid = 3'b000;
        check_eq("t5_d_en", 64'(out_write_en), 64'h0);
        check_eq("t5_d_qp7", 64'(query_pending[0]), 64'h1);
        tick();                                  // edge e: committed once
        check_eq("t5_e_en", 64'(out_write_en), 64'h1);
        check_eq("t5_e_sel", 64'(out_write_sel), 64'h7);
        check_eq("t5_e_data", 64'(out_write_data), 64'h1234_5678);
        tick();
        check_eq("t5_f_en", 64'(out_write_en), 64'h0);
        tick();
        check_eq("t5_g_en", 64'(out_write_en), 64'h0);
        check_eq("t5_g_idle", 64'(idle), 64'h1);

        // 6. Write to r0
        set_req(0, 4'd0, 32'hFFFF_FFFF);
        set_query(4'd0, 4'd3);
        in_valid = 3'b001;
        #1;
        check_eq("t6_ready0_before", 64'(in_ready[0]), 64'h1);
        tick();
        in_valid = 3'b000;
`ifdef REG_FILE_WRITE_ARB_R0_DISCARD_EN
        check_eq("t6_e1_ready", 64'(in_ready), 64'h7);
        check_eq("t6_e1_qp", 64'(query_pending), 64'h0);
        check_eq("t6_e1_idle", 64'(idle), 64'h1);
        tick();
        check_eq("t6_e2_en", 64'(out_write_en), 64'h0);
        check_eq("t6_e2_qp", 64'(query_pending), 64'h0);
`else
        check_eq("t6_e1_ready", 64'(in_ready), 64'h6);
        check_eq("t6_e1_qp", 64'(query_pending), 64'h1);
        tick();
        check_eq("t6_e2_en", 64'(out_write_en), 64'h1);
        check_eq("t6_e2_sel", 64'(out_write_sel), 64'h0);
        check_eq("t6_e2_data", 64'(out_write_data), 64'hFFFF_FFFF);
        check_eq("t6_e2_qp", 64'(query_pending), 64'h1);
`endif
        tick();
        check_eq("t6_end_idle", 64'(idle), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
